// File: rtl/mcu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mcu_pkg
// Purpose  : Shared definitions for the convolution MCU: top-level state
//            encoding seen by the mux array, a constant-capable clog2, and
//            the sliding-window memory index helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mcu_pkg;

   // Encoding is visible on o_state and decoded by the mux array.
   typedef enum logic [1:0] {
      ST_LOAD = 2'b00,
      ST_PROC = 2'b01,
      ST_OUT  = 2'b10,
      ST_IDLE = 2'b11
   } mcu_state_e;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result++;
      end
      return result;
   endfunction

   // Row memory holding window offset k when the window base is s*n.
   // There are n+2 row memories used as a circular buffer.
   function automatic int win_mem(input int s, input int k, input int n);
      return (s * n + k) % (n + 2);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mcu_addr_delay.sv
`default_nettype none
// ============================================================================
// Module   : mcu_addr_delay
// Purpose  : Shift register carrying the PROC read address and a valid bit
//            so that the write-back address lines up with the convolver
//            result.
// Ports    : i_clk, i_rst_n   clock, async active-low reset
//            i_valid, i_addr  read issued this cycle (next-state view)
//            o_valid, o_addr  same address DEPTH-1 cycles later
// Revision : 1.0 - initial release
// ============================================================================
module mcu_addr_delay #(
   parameter int BITS_ADDR = 10,
   parameter int DEPTH     = 3
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_valid,
   input  logic [BITS_ADDR-1:0] i_addr,
   output logic                 o_valid,
   output logic [BITS_ADDR-1:0] o_addr
);

   logic [DEPTH-1:0]     valid_q, valid_d;
   logic [BITS_ADDR-1:0] addr_q [DEPTH];
   logic [BITS_ADDR-1:0] addr_d [DEPTH];

   always_comb begin
      valid_d[0] = i_valid;
      addr_d[0]  = i_addr;
      for (int i = 1; i < DEPTH; i++) begin
         valid_d[i] = valid_q[i-1];
         addr_d[i]  = addr_q[i-1];
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         valid_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= addr_d[i];
         end
      end
   end

   assign o_valid = valid_q[DEPTH-1];
   assign o_addr  = addr_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/mcu_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : mcu_ctrl_fsm
// Purpose  : Sequencer for the convolution MCU. Runs pixel loading, the
//            convolution pass with write-back, and result readout for one
//            block of N output rows, rotating the row-memory window.
// Ports    : i_CLK, i_RST_n        clock, async active-low reset
//            i_start, i_first      start a block / first block of image
//            i_imgLength           pixels per row, latched at start
//            i_inValid, i_outReq   host pixel strobe / result request
//            o_state, o_substate   mux array state and window rotation
//            o_memSelect           memory written in LOAD / read in OUT
//            o_rdAddr, o_wrAddr    row memory addresses
//            o_we                  per-memory write enables
//            o_outValid            result pixel valid
//            o_blockDone, o_busy   end-of-block pulse, not-idle flag
// Revision : 1.0 - initial release
// ============================================================================
module mcu_ctrl_fsm
   import mcu_pkg::*;
#(
   parameter int N         = 2,
   parameter int BITS_ADDR = 10,
   parameter int CONV_LAT  = 2,
   localparam int NM  = N + 2,
   localparam int SW  = (clog2(NM / 2) < 1) ? 1 : clog2(NM / 2),
   localparam int MSW = clog2(N + 1),
   localparam int RW  = clog2(N + 3)
) (
   input  logic                 i_CLK,
   input  logic                 i_RST_n,
   input  logic                 i_start,
   input  logic                 i_first,
   input  logic [BITS_ADDR-1:0] i_imgLength,
   input  logic                 i_inValid,
   input  logic                 i_outReq,
   output logic [1:0]           o_state,
   output logic [SW-1:0]        o_substate,
   output logic [MSW-1:0]       o_memSelect,
   output logic [BITS_ADDR-1:0] o_rdAddr,
   output logic [BITS_ADDR-1:0] o_wrAddr,
   output logic [NM-1:0]        o_we,
   output logic                 o_outValid,
   output logic                 o_blockDone,
   output logic                 o_busy
);

   mcu_state_e           state_q, state_d;
   logic [SW-1:0]        substate_q, substate_d;
   logic [BITS_ADDR-1:0] len_q, len_d;
   logic [RW-1:0]        rows_q, rows_d;
   logic [RW-1:0]        row_q, row_d;
   logic [BITS_ADDR-1:0] addr_q, addr_d;
   logic [BITS_ADDR-1:0] rd_addr_q, rd_addr_d;
   logic                 rd_act_q, rd_act_d;
   logic [BITS_ADDR-1:0] wr_addr_q, wr_addr_d;
   logic [MSW-1:0]       mem_select_q, mem_select_d;
   logic [NM-1:0]        we_q, we_d;
   logic                 wb_q, wb_d;
   logic                 out_valid_q, out_valid_d;
   logic                 block_done_q, block_done_d;

   logic [MSW-1:0]       load_mem, out_mem_first, out_mem_next;
   logic [NM-1:0]        wb_mask;
   logic                 dly_valid;
   logic [BITS_ADDR-1:0] dly_addr;

   // Read addresses are fed in from the next-state side so the delayed copy
   // leaves the shift register one cycle before it is registered into o_we.
   mcu_addr_delay #(
      .BITS_ADDR (BITS_ADDR),
      .DEPTH     (1 + CONV_LAT)
   ) u_addr_delay (
      .i_clk   (i_CLK),
      .i_rst_n (i_RST_n),
      .i_valid (rd_act_d),
      .i_addr  (rd_addr_d),
      .o_valid (dly_valid),
      .o_addr  (dly_addr)
   );

   always_comb begin
      load_mem      = MSW'(win_mem(int'(substate_q), int'(row_q), N));
      out_mem_first = MSW'(win_mem(int'(substate_q), 0, N));
      out_mem_next  = MSW'(win_mem(int'(substate_q), int'(row_q) + 1, N));
      // Write-back lands on the N memories of the current window at once.
      wb_mask = '0;
      for (int k = 0; k < N; k++) begin
         wb_mask[MSW'(win_mem(int'(substate_q), k, N))] = 1'b1;
      end
   end

   always_comb begin
      state_d      = state_q;
      substate_d   = substate_q;
      len_d        = len_q;
      rows_d       = rows_q;
      row_d        = row_q;
      addr_d       = addr_q;
      rd_addr_d    = rd_addr_q;
      rd_act_d     = rd_act_q;
      wr_addr_d    = wr_addr_q;
      mem_select_d = mem_select_q;
      we_d         = '0;
      wb_d         = 1'b0;
      out_valid_d  = 1'b0;
      block_done_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (i_start && (i_imgLength != '0)) begin
               state_d = ST_LOAD;
               len_d   = i_imgLength;
               rows_d  = i_first ? RW'(NM) : RW'(N);
               row_d   = '0;
               addr_d  = '0;
               // A first block fills every memory in order 0..N+1.
               if (i_first) begin
                  substate_d = '0;
               end
            end
         end

         ST_LOAD: begin
            if (i_inValid) begin
               wr_addr_d    = addr_q;
               mem_select_d = load_mem;
               we_d         = {{(NM-1){1'b0}}, 1'b1} << load_mem;
               if (addr_q == len_q - 1'b1) begin
                  addr_d = '0;
                  row_d  = row_q + 1'b1;
                  if (row_q == rows_q - 1'b1) begin
                     state_d   = ST_PROC;
                     rd_addr_d = '0;
                     rd_act_d  = 1'b1;
                  end
               end else begin
                  addr_d = addr_q + 1'b1;
               end
            end
         end

         ST_PROC: begin
            if (rd_act_q) begin
               if (rd_addr_q == len_q - 1'b1) begin
                  rd_act_d = 1'b0;
               end else begin
                  rd_addr_d = rd_addr_q + 1'b1;
               end
            end
            if (dly_valid) begin
               we_d      = wb_mask;
               wr_addr_d = dly_addr;
               wb_d      = 1'b1;
            end
            // wb_q separates the final write-back from the last LOAD write,
            // which is still on o_we in the first PROC cycle.
            if (wb_q && (wr_addr_q == len_q - 1'b1)) begin
               state_d      = ST_OUT;
               rd_addr_d    = '0;
               row_d        = '0;
               mem_select_d = out_mem_first;
            end
         end

         ST_OUT: begin
            // Read address is staged ahead so data is valid one cycle after
            // the request is accepted.
            if (block_done_q) begin
               state_d    = ST_IDLE;
               substate_d = (substate_q == SW'(NM/2 - 1)) ? '0 : substate_q + 1'b1;
            end else if (i_outReq) begin
               out_valid_d = 1'b1;
               if (rd_addr_q == len_q - 1'b1) begin
                  rd_addr_d    = '0;
                  row_d        = row_q + 1'b1;
                  mem_select_d = out_mem_next;
                  if (row_q == RW'(N - 1)) begin
                     block_done_d = 1'b1;
                  end
               end else begin
                  rd_addr_d = rd_addr_q + 1'b1;
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_CLK or negedge i_RST_n) begin
      if (!i_RST_n) begin
         state_q      <= ST_IDLE;
         substate_q   <= '0;
         len_q        <= '0;
         rows_q       <= '0;
         row_q        <= '0;
         addr_q       <= '0;
         rd_addr_q    <= '0;
         rd_act_q     <= 1'b0;
         wr_addr_q    <= '0;
         mem_select_q <= '0;
         we_q         <= '0;
         wb_q         <= 1'b0;
         out_valid_q  <= 1'b0;
         block_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         substate_q   <= substate_d;
         len_q        <= len_d;
         rows_q       <= rows_d;
         row_q        <= row_d;
         addr_q       <= addr_d;
         rd_addr_q    <= rd_addr_d;
         rd_act_q     <= rd_act_d;
         wr_addr_q    <= wr_addr_d;
         mem_select_q <= mem_select_d;
         we_q         <= we_d;
         wb_q         <= wb_d;
         out_valid_q  <= out_valid_d;
         block_done_q <= block_done_d;
      end
   end

   assign o_state     = state_q;
   assign o_substate  = substate_q;
   assign o_memSelect = mem_select_q;
   assign o_rdAddr    = rd_addr_q;
   assign o_wrAddr    = wr_addr_q;
   assign o_we        = we_q;
   assign o_outValid  = out_valid_q;
   assign o_blockDone = block_done_q;
   assign o_busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mcu_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_mcu_ctrl_fsm
// Purpose  : Self-checking bench for mcu_ctrl_fsm. Expected row-memory
//            writes and readout accesses are queued from the block rules;
//            a monitor pops and compares them as the DUT presents them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mcu_ctrl_fsm;

   localparam int N   = 2;
   localparam int BA  = 10;
   localparam int CL  = 2;
   localparam int NM  = N + 2;
   localparam int MSW = 2;
   localparam logic [1:0] S_LOAD = 2'b00;
   localparam logic [1:0] S_PROC = 2'b01;
   localparam logic [1:0] S_OUT  = 2'b10;
   localparam logic [1:0] S_IDLE = 2'b11;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start, first, in_valid, out_req;
   logic [BA-1:0] img_len;
   logic [1:0]    state;
   logic [0:0]    substate;
   logic [MSW-1:0] mem_select;
   logic [BA-1:0] rd_addr, wr_addr;
   logic [NM-1:0] we;
   logic          out_valid, block_done, busy;

   always #5 clk = ~clk;

   mcu_ctrl_fsm #(.N(N), .BITS_ADDR(BA), .CONV_LAT(CL)) dut (
      .i_CLK       (clk),
      .i_RST_n     (rst_n),
      .i_start     (start),
      .i_first     (first),
      .i_imgLength (img_len),
      .i_inValid   (in_valid),
      .i_outReq    (out_req),
      .o_state     (state),
      .o_substate  (substate),
      .o_memSelect (mem_select),
      .o_rdAddr    (rd_addr),
      .o_wrAddr    (wr_addr),
      .o_we        (we),
      .o_outValid  (out_valid),
      .o_blockDone (block_done),
      .o_busy      (busy)
   );

   typedef struct { logic [NM-1:0] we; logic [BA-1:0] addr; bit proc; } wr_exp_t;
   typedef struct { logic [MSW-1:0] msel; logic [BA-1:0] addr; bit done; } out_exp_t;
   wr_exp_t  wq[$];
   out_exp_t oq[$];

   int checks = 0;
   int failures = 0;
   int model_sub = 0;
   int cur_len = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic flag(input string nm, input logic [31:0] act);
      checks++;
      failures++;
      $display("FAIL %s actual=%0d expected=nothing at %0t", nm, act, $time);
   endtask

   function automatic int win(input int s, input int k);
      return (s * N + k) % NM;
   endfunction

   // Expected activity of one complete block, straight from the block rules.
   task automatic push_block(input int len, input bit first_blk);
      int rows;
      wr_exp_t w;
      out_exp_t o;
      logic [NM-1:0] mask;
      if (first_blk) model_sub = 0;
      rows = first_blk ? NM : N;
      for (int p = 0; p < rows * len; p++) begin
         w.we = '0;
         w.we[win(model_sub, p / len)] = 1'b1;
         w.addr = BA'(p % len);
         w.proc = 1'b0;
         wq.push_back(w);
      end
      mask = '0;
      for (int k = 0; k < N; k++) mask[win(model_sub, k)] = 1'b1;
      for (int a = 0; a < len; a++) begin
         w.we = mask; w.addr = BA'(a); w.proc = 1'b1;
         wq.push_back(w);
      end
      for (int k = 0; k < N; k++) begin
         for (int a = 0; a < len; a++) begin
            o.msel = MSW'(win(model_sub, k));
            o.addr = BA'(a);
            o.done = (k == N - 1) && (a == len - 1);
            oq.push_back(o);
         end
      end
      model_sub = (model_sub + 1) % (NM / 2);
   endtask

   task automatic wait_state(input logic [1:0] want, input int limit, input bit noise, input string nm);
      int n = 0;
      while (state !== want && n < limit) begin
         in_valid = noise && ($urandom % 3 == 0);
         out_req  = noise && ($urandom % 3 == 0);
         @(posedge clk); #1;
         n++;
      end
      in_valid = 1'b0;
      out_req  = 1'b0;
      check(nm, state, want);
   endtask

   task automatic run_block(input int len, input bit first_blk, input bit noise, input int reset_after);
      int rows, cnt, guard;
      cur_len = len;
      push_block(len, first_blk);
      rows = first_blk ? NM : N;
      start = 1'b1; first = first_blk; img_len = BA'(len);
      @(posedge clk); #1;
      start = 1'b0;
      check("state_load", state, S_LOAD);
      check("busy_load", busy, 1);
      cnt = 0; guard = 0;
      while (cnt < rows * len && guard < 4000) begin
         in_valid = ($urandom % 4 != 0);
         out_req  = noise && ($urandom % 4 == 0);
         start    = noise && ($urandom % 4 == 0);
         first    = 1'($urandom);
         img_len  = BA'($urandom);
         @(posedge clk);
         if (in_valid) cnt++;
         #1;
         guard++;
      end
      in_valid = 1'b0; out_req = 1'b0; start = 1'b0;
      check("load_count", cnt, rows * len);
      if (reset_after > 0) begin
         check("state_proc", state, S_PROC);
         repeat (reset_after) @(posedge clk);
         #1;
         rst_n = 1'b0;
         #2;
         check("rst_state", state, S_IDLE);
         check("rst_we", we, 0);
         check("rst_substate", substate, 0);
         check("rst_out_valid", out_valid, 0);
         check("rst_busy", busy, 0);
         wq.delete();
         oq.delete();
         model_sub = 0;
         @(posedge clk); #1;
         rst_n = 1'b1;
         @(posedge clk); #1;
         return;
      end
      wait_state(S_OUT, 64, noise, "reach_out");
      cnt = 0; guard = 0;
      while (cnt < N * len && guard < 4000) begin
         out_req  = ($urandom % 3 != 0);
         in_valid = noise && ($urandom % 4 == 0);
         @(posedge clk);
         if (out_req) cnt++;
         #1;
         guard++;
      end
      // One more request during the blockDone cycle must be ignored.
      out_req = noise; in_valid = 1'b0;
      @(posedge clk); #1;
      out_req = 1'b0;
      check("out_count", cnt, N * len);
      wait_state(S_IDLE, 8, 1'b0, "reach_idle");
      check("substate", substate, model_sub);
      check("busy_idle", busy, 0);
   endtask

   // Monitor: compares every presented write and result against the queues.
   logic [1:0]     prev_state = S_IDLE;
   logic [MSW-1:0] prev_msel = '0;
   logic [BA-1:0]  prev_rd = '0;
   bit             prev_done = 1'b0;
   int             proc_idx = 0;

   always @(negedge clk) begin
      wr_exp_t w;
      out_exp_t o;
      if (!rst_n) begin
         prev_state = S_IDLE;
         prev_done  = 1'b0;
         proc_idx   = 0;
      end else begin
         if (we != '0) begin
            if (wq.size() == 0) begin
               flag("unexpected_we", we);
            end else begin
               w = wq.pop_front();
               check("we", we, w.we);
               check("wr_addr", wr_addr, w.addr);
               if (w.proc) check("wb_cycle", proc_idx, w.addr + 1 + CL);
            end
         end
         if (state == S_PROC) begin
            if (proc_idx < cur_len) check("proc_rd_addr", rd_addr, proc_idx);
            proc_idx++;
         end else begin
            if (prev_state == S_PROC) check("proc_len", proc_idx, cur_len + 1 + CL);
            proc_idx = 0;
         end
         if (out_valid) begin
            if (oq.size() == 0) begin
               flag("unexpected_out_valid", out_valid);
            end else begin
               o = oq.pop_front();
               check("out_msel", prev_msel, o.msel);
               check("out_addr", prev_rd, o.addr);
               check("out_done", block_done, o.done);
            end
         end else if (block_done) begin
            flag("done_without_valid", block_done);
         end
         if (prev_done) check("idle_after_done", state, S_IDLE);
         prev_state = state;
         prev_msel  = mem_select;
         prev_rd    = rd_addr;
         prev_done  = block_done;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; first = 1'b0; img_len = '0;
      in_valid = 1'b0; out_req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", state, S_IDLE);
      check("reset_we", we, 0);
      check("reset_substate", substate, 0);
      check("reset_out_valid", out_valid, 0);
      check("reset_block_done", block_done, 0);
      check("reset_busy", busy, 0);
      check("reset_rd_addr", rd_addr, 0);
      check("reset_wr_addr", wr_addr, 0);
      check("reset_mem_select", mem_select, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Zero length start and stray strobes in IDLE do nothing.
      start = 1'b1; first = 1'b1; img_len = '0; in_valid = 1'b1; out_req = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; in_valid = 1'b0; out_req = 1'b0;
      check("len0_state", state, S_IDLE);
      check("len0_busy", busy, 0);

      run_block(4, 1'b1, 1'b0, 0);
      run_block(4, 1'b0, 1'b1, 3);
      run_block(4, 1'b1, 1'b0, 0);
      run_block(4, 1'b0, 1'b0, 0);
      for (int i = 0; i < 12; i++) begin
         run_block(int'($urandom_range(1, 8)), ($urandom % 3 == 0), 1'b1, 0);
      end

      repeat (4) @(posedge clk);
      #1;
      check("wq_empty", wq.size(), 0);
      check("oq_empty", oq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
